// File: rtl/hazard_stall_unit_if.sv
// Pipeline-control bundle between the ID-stage hazard stall unit and the pipeline.
// The slave modport is the stall unit; the master modport is the surrounding pipeline.
interface hazard_stall_unit_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       i_IF_ID_Rs;
    logic [4:0]       i_IF_ID_Rt;
    logic             i_ID_uses_Rs;
    logic             i_ID_uses_Rt;
    logic             i_ID_branch;
    logic             i_ID_branch_taken;
    logic             i_ID_jump;
    logic [4:0]       i_ID_EX_Rd;
    logic             i_ID_EX_reg_write;
    logic             i_ID_EX_mem_read;
    logic [4:0]       i_EX_MEM_Rd;
    logic             i_EX_MEM_mem_read;
    logic             i_EX_busy;
    logic             o_PC_write;
    logic             o_IF_ID_write;
    logic             o_IF_ID_flush;
    logic             o_ID_EX_write;
    logic             o_ID_EX_bubble;
    logic [1:0]       o_state;
    logic             o_stall_timeout;
    logic [CNT_W-1:0] o_stall_count;
    logic [CNT_W-1:0] o_flush_count;

    modport master (
        output i_IF_ID_Rs, i_IF_ID_Rt, i_ID_uses_Rs, i_ID_uses_Rt, i_ID_branch,
               i_ID_branch_taken, i_ID_jump, i_ID_EX_Rd, i_ID_EX_reg_write,
               i_ID_EX_mem_read, i_EX_MEM_Rd, i_EX_MEM_mem_read, i_EX_busy,
        input  o_PC_write, o_IF_ID_write, o_IF_ID_flush, o_ID_EX_write, o_ID_EX_bubble,
               o_state, o_stall_timeout, o_stall_count, o_flush_count
    );

    modport slave (
        input  i_IF_ID_Rs, i_IF_ID_Rt, i_ID_uses_Rs, i_ID_uses_Rt, i_ID_branch,
               i_ID_branch_taken, i_ID_jump, i_ID_EX_Rd, i_ID_EX_reg_write,
               i_ID_EX_mem_read, i_EX_MEM_Rd, i_EX_MEM_mem_read, i_EX_busy,
        output o_PC_write, o_IF_ID_write, o_IF_ID_flush, o_ID_EX_write, o_ID_EX_bubble,
               o_state, o_stall_timeout, o_stall_count, o_flush_count
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// ID-stage stall/flush control for hazards forwarding cannot resolve, with a
// stall-streak watchdog and saturating stall/flush performance counters.
module hazard_stall_unit #(
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned MAX_STALL = 64,
    parameter int unsigned STREAK_W  = 8
) (
    input logic               i_clk,
    input logic               i_rst_n,
    hazard_stall_unit_if.slave hsu_io
);

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StHaz   = 2'd1,
        StBusy  = 2'd2,
        StFlush = 2'd3
    } action_e;

    // Register 0 is hardwired, so it can never be a pending producer.
    function automatic logic match_x(input logic [4:0] rd, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic use_rs,
                                     input logic use_rt);
        return (rd != 5'd0) && ((use_rs && (rd == rs)) || (use_rt && (rd == rt)));
    endfunction

    action_e               action;
    action_e               state_q;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;
    logic [STREAK_W-1:0]   streak_q, streak_d;
    logic                  timeout_q, timeout_d;
    logic                  ex_match, mem_match, haz, redirect, stalling;
    logic                  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble;

    assign ex_match  = match_x(hsu_io.i_ID_EX_Rd, hsu_io.i_IF_ID_Rs, hsu_io.i_IF_ID_Rt,
                               hsu_io.i_ID_uses_Rs, hsu_io.i_ID_uses_Rt);
    assign mem_match = match_x(hsu_io.i_EX_MEM_Rd, hsu_io.i_IF_ID_Rs, hsu_io.i_IF_ID_Rt,
                               hsu_io.i_ID_uses_Rs, hsu_io.i_ID_uses_Rt);

    assign haz = (hsu_io.i_ID_EX_mem_read && ex_match)
               || (hsu_io.i_ID_branch && hsu_io.i_ID_EX_reg_write && ex_match)
               || (hsu_io.i_ID_branch && hsu_io.i_EX_MEM_mem_read && mem_match);

    assign redirect = (hsu_io.i_ID_branch && hsu_io.i_ID_branch_taken) || hsu_io.i_ID_jump;

    // Priority: reset, busy, data hazard, redirect, run.
    always_comb begin
        action       = StRun;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        if (!i_rst_n) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_write = 1'b0;
        end else if (hsu_io.i_EX_busy) begin
            action      = StBusy;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_write = 1'b0;
        end else if (haz) begin
            action       = StHaz;
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (redirect) begin
            action      = StFlush;
            if_id_flush = 1'b1;
        end
    end

    assign stalling = (action == StHaz) || (action == StBusy);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        streak_d    = '0;
        if (stalling && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if ((action == StFlush) && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
        if (stalling) begin
            streak_d = (streak_q != '1) ? streak_q + 1'b1 : streak_q;
        end
        timeout_d = timeout_q || (stalling && (streak_d == STREAK_W'(MAX_STALL)));
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= StRun;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            streak_q    <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= action;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            streak_q    <= streak_d;
            timeout_q   <= timeout_d;
        end
    end

    assign hsu_io.o_PC_write      = pc_write;
    assign hsu_io.o_IF_ID_write   = if_id_write;
    assign hsu_io.o_IF_ID_flush   = if_id_flush;
    assign hsu_io.o_ID_EX_write   = id_ex_write;
    assign hsu_io.o_ID_EX_bubble  = id_ex_bubble;
    assign hsu_io.o_state         = state_q;
    assign hsu_io.o_stall_timeout = timeout_q;
    assign hsu_io.o_stall_count   = stall_cnt_q;
    assign hsu_io.o_flush_count   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit (CNT_W=3, MAX_STALL=4) with a queue
// scoreboard for the combinational controls and the registered status.
module tb_hazard_stall_unit;

    localparam int unsigned CntW = 3;

    // Control vector order: {PC_write, IF_ID_write, ID_EX_write, bubble, flush}
    localparam logic [4:0] CRun   = 5'b11100;
    localparam logic [4:0] CHaz   = 5'b00110;
    localparam logic [4:0] CStop  = 5'b00000;
    localparam logic [4:0] CFlush = 5'b11101;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [4:0]        comb_q[$];
    logic [4+2*CntW:0] reg_q[$];

    hazard_stall_unit_if #(.CNT_W(CntW)) hsu_if ();

    hazard_stall_unit #(
        .CNT_W    (CntW),
        .MAX_STALL(4),
        .STREAK_W (8)
    ) u_dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .hsu_io (hsu_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        hsu_if.i_IF_ID_Rs        = 5'd0;
        hsu_if.i_IF_ID_Rt        = 5'd0;
        hsu_if.i_ID_uses_Rs      = 1'b0;
        hsu_if.i_ID_uses_Rt      = 1'b0;
        hsu_if.i_ID_branch       = 1'b0;
        hsu_if.i_ID_branch_taken = 1'b0;
        hsu_if.i_ID_jump         = 1'b0;
        hsu_if.i_ID_EX_Rd        = 5'd0;
        hsu_if.i_ID_EX_reg_write = 1'b0;
        hsu_if.i_ID_EX_mem_read  = 1'b0;
        hsu_if.i_EX_MEM_Rd       = 5'd0;
        hsu_if.i_EX_MEM_mem_read = 1'b0;
        hsu_if.i_EX_busy         = 1'b0;
    endtask

    task automatic load_use(input logic [4:0] rd);
        hsu_if.i_ID_EX_mem_read = 1'b1;
        hsu_if.i_ID_EX_Rd       = rd;
        hsu_if.i_IF_ID_Rs       = rd;
        hsu_if.i_ID_uses_Rs     = 1'b1;
    endtask

    // One cycle: check controls before the edge, status after it.
    task automatic cyc(input string tag, input logic [4:0] exp_c, input logic [1:0] st,
                       input logic to, input logic [CntW-1:0] sc, input logic [CntW-1:0] fc);
        logic [4:0]        obs_c, e_c;
        logic [4+2*CntW:0] obs_r, e_r;
        comb_q.push_back(exp_c);
        #1;
        obs_c = {hsu_if.o_PC_write, hsu_if.o_IF_ID_write, hsu_if.o_ID_EX_write,
                 hsu_if.o_ID_EX_bubble, hsu_if.o_IF_ID_flush};
        e_c = comb_q.pop_front();
        checks++;
        assert (obs_c === e_c) else begin
            failures++;
            $error("FAIL %s ctrl observed=%b expected=%b", tag, obs_c, e_c);
        end
        @(posedge clk);
        #1;
        reg_q.push_back({st, to, sc, fc});
        obs_r = {hsu_if.o_state, hsu_if.o_stall_timeout, hsu_if.o_stall_count,
                 hsu_if.o_flush_count};
        e_r = reg_q.pop_front();
        checks++;
        assert (obs_r === e_r) else begin
            failures++;
            $error("FAIL %s status observed=%b expected=%b", tag, obs_r, e_r);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        idle();
        rst_n = 1'b0;
        cyc("reset", CStop, 2'd0, 1'b0, 3'd0, 3'd0);
        rst_n = 1'b1;
        cyc("idle_run", CRun, 2'd0, 1'b0, 3'd0, 3'd0);

        load_use(5'd5);
        cyc("load_use", CHaz, 2'd1, 1'b0, 3'd1, 3'd0);
        idle(); load_use(5'd0);
        cyc("reg_zero", CRun, 2'd0, 1'b0, 3'd1, 3'd0);
        idle(); load_use(5'd5); hsu_if.i_ID_uses_Rs = 1'b0;
        cyc("no_use_rs", CRun, 2'd0, 1'b0, 3'd1, 3'd0);

        // Branch reading r7 behind a load to r7: EX then MEM, then resolve taken.
        idle();
        hsu_if.i_ID_branch = 1'b1; hsu_if.i_ID_branch_taken = 1'b1;
        hsu_if.i_ID_uses_Rt = 1'b1; hsu_if.i_IF_ID_Rt = 5'd7;
        hsu_if.i_ID_EX_Rd = 5'd7; hsu_if.i_ID_EX_reg_write = 1'b1;
        hsu_if.i_ID_EX_mem_read = 1'b1;
        cyc("br_load_ex", CHaz, 2'd1, 1'b0, 3'd2, 3'd0);
        hsu_if.i_ID_EX_Rd = 5'd0; hsu_if.i_ID_EX_reg_write = 1'b0;
        hsu_if.i_ID_EX_mem_read = 1'b0;
        hsu_if.i_EX_MEM_Rd = 5'd7; hsu_if.i_EX_MEM_mem_read = 1'b1;
        cyc("br_load_mem", CHaz, 2'd1, 1'b0, 3'd3, 3'd0);
        hsu_if.i_EX_MEM_Rd = 5'd0; hsu_if.i_EX_MEM_mem_read = 1'b0;
        cyc("br_taken", CFlush, 2'd3, 1'b0, 3'd3, 3'd1);
        hsu_if.i_ID_EX_Rd = 5'd7; hsu_if.i_ID_EX_reg_write = 1'b1;
        cyc("br_alu", CHaz, 2'd1, 1'b0, 3'd4, 3'd1);
        hsu_if.i_ID_EX_Rd = 5'd0; hsu_if.i_ID_EX_reg_write = 1'b0;
        hsu_if.i_ID_branch_taken = 1'b0;
        cyc("br_not_taken", CRun, 2'd0, 1'b0, 3'd4, 3'd1);

        idle(); rst_n = 1'b0;
        cyc("reset2", CStop, 2'd0, 1'b0, 3'd0, 3'd0);
        rst_n = 1'b1;

        load_use(5'd5); hsu_if.i_EX_busy = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            cyc($sformatf("busy_haz%0d", i), CStop, 2'd2, 1'b0, 3'(i), 3'd0);
        end
        idle();
        cyc("busy_release", CRun, 2'd0, 1'b0, 3'd3, 3'd0);

        // Streak restarts at 0, so the flag rises only on the 4th busy edge.
        hsu_if.i_EX_busy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cyc($sformatf("wdog%0d", i), CStop, 2'd2, (i == 4), 3'(3 + i), 3'd0);
        end
        idle(); hsu_if.i_ID_jump = 1'b1;
        cyc("wdog_jump", CFlush, 2'd3, 1'b1, 3'd7, 3'd1);
        idle();
        cyc("wdog_sticky", CRun, 2'd0, 1'b1, 3'd7, 3'd1);

        load_use(5'd9); rst_n = 1'b0;
        cyc("reset_mid_haz", CStop, 2'd0, 1'b0, 3'd0, 3'd0);
        rst_n = 1'b1; idle();

        hsu_if.i_ID_jump = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            cyc($sformatf("jump%0d", i), CFlush, 2'd3, 1'b0, 3'd0, (i > 7) ? 3'd7 : 3'(i));
        end
        rst_n = 1'b0;
        cyc("reset_pulse", CStop, 2'd0, 1'b0, 3'd0, 3'd0);
        rst_n = 1'b1;
        cyc("after_reset", CFlush, 2'd3, 1'b0, 3'd0, 3'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "bench timed out");
    end

endmodule
